modhalf_iter: RTL and testbench

//  Multi-lane iterative scaler: b = a * 2^-k mod Q, with k chosen per transaction (0..MAXSH).

---
 rtl/kyber_arith_pkg.sv | 16 +
 rtl/modhalf_step.sv | 22 ++
 rtl/modhalf_iter.sv | 131 +++++++++++++
 tb/tb_modhalf_iter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_arith_pkg.sv
// Shared Kyber arithmetic constants, coefficient type and halver FSM states.
package kyber_arith_pkg;

    localparam int unsigned KYBER_Q     = 3329;
    localparam int unsigned KYBER_HALFQ = 1665;
    localparam int unsigned COEF_WID    = 12;

    typedef logic [COEF_WID-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } modhalf_state_t;

endpackage

// File: rtl/modhalf_step.sv
// One modular halving step: y = x * 2^-1 mod Q, for x < Q.
module modhalf_step
    import kyber_arith_pkg::*;
#(
    parameter int unsigned WID   = COEF_WID,
    parameter int unsigned HALFQ = KYBER_HALFQ
) (
    input  logic [WID-1:0] x_i,
    output logic [WID-1:0] y_o
);

    localparam logic [WID-1:0] HalfQ = WID'(HALFQ);

    // Odd x: (x + Q) / 2 == (x >> 1) + (Q + 1) / 2, which stays below Q.
    always_comb begin
        y_o = x_i >> 1;
        if (x_i[0]) begin
            y_o = (x_i >> 1) + HalfQ;
        end
    end

endmodule

// File: rtl/modhalf_iter.sv
// Multi-lane iterative scaler: b = a * 2^-k mod Q, one halving step per cycle.
// Optional range check on accepted inputs: define MODHALFI_RANGE_CHK_EN to add the err port.
module modhalf_iter
    import kyber_arith_pkg::*;
#(
    parameter int unsigned WID   = COEF_WID,
    parameter int unsigned Q     = KYBER_Q,
    parameter int unsigned HALFQ = KYBER_HALFQ,
    parameter int unsigned LANES = 4,
    parameter int unsigned MAXSH = 7,
    parameter int unsigned SHW   = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 a_vld_i,
    output logic                 a_rdy_o,
    input  logic [LANES*WID-1:0] a_i,
    input  logic [SHW-1:0]       shamt_i,
    output logic                 b_vld_o,
    input  logic                 b_rdy_i,
    output logic [LANES*WID-1:0] b_o,
`ifdef MODHALFI_RANGE_CHK_EN
    output logic                 busy_o,
    output logic                 err_o
`else
    output logic                 busy_o
`endif
);

    localparam logic [SHW-1:0] MaxSh = SHW'(MAXSH);

    modhalf_state_t       state_q;
    logic [SHW-1:0]       cnt_q;
    logic [LANES*WID-1:0] data_q;
    logic [LANES*WID-1:0] data_step;
    logic                 b_vld_q;
    logic                 busy_q;
    logic [SHW-1:0]       shamt_k;
    logic                 accept;

    // A finished result can be handed off and replaced in the same cycle.
    always_comb begin
        a_rdy_o = (state_q == IDLE) || ((state_q == DONE) && b_rdy_i);
        accept  = a_vld_i && a_rdy_o;
        shamt_k = (shamt_i > MaxSh) ? MaxSh : shamt_i;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        modhalf_step #(
            .WID   (WID),
            .HALFQ (HALFQ)
        ) u_step (
            .x_i (data_q[i*WID +: WID]),
            .y_o (data_step[i*WID +: WID])
        );
    end

`ifdef MODHALFI_RANGE_CHK_EN
    localparam logic [WID-1:0] QV = WID'(Q);

    logic [LANES-1:0] lane_oor;
    logic             range_err;
    logic             err_q;

    for (genvar i = 0; i < LANES; i++) begin : g_chk
        assign lane_oor[i] = (a_i[i*WID +: WID] >= QV);
    end

    assign range_err = |lane_oor;

    // Error flag follows the result it belongs to; dropped on handoff.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= range_err;
        end else if ((state_q == DONE) && b_rdy_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q && b_vld_q;
`endif

    // Transaction FSM: load on accept, halve every lane per RUN cycle, hold in DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            b_vld_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (accept) begin
            data_q <= a_i;
            cnt_q  <= shamt_k;
            busy_q <= 1'b1;
            if (shamt_k == '0) begin
                state_q <= DONE;
                b_vld_q <= 1'b1;
            end else begin
                state_q <= RUN;
                b_vld_q <= 1'b0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    data_q <= data_step;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        state_q <= DONE;
                        b_vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (b_rdy_i) begin
                        state_q <= IDLE;
                        b_vld_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign b_vld_o = b_vld_q;
    assign busy_o  = busy_q;
    assign b_o     = data_q;

endmodule

// File: tb/tb_modhalf_iter.sv
// Directed self-checking bench for modhalf_iter (default parameters).
module tb_modhalf_iter;

    localparam int W = 12;
    localparam int L = 4;
    localparam int SW = 3;
    localparam int QM = 3329;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_vld;
    logic          a_rdy;
    logic [L*W-1:0] a;
    logic [SW-1:0] shamt;
    logic          b_vld;
    logic          b_rdy;
    logic [L*W-1:0] b;
    logic          busy;
`ifdef MODHALFI_RANGE_CHK_EN
    logic          err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    modhalf_iter dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .a_vld_i (a_vld),
        .a_rdy_o (a_rdy),
        .a_i     (a),
        .shamt_i (shamt),
        .b_vld_o (b_vld),
        .b_rdy_i (b_rdy),
        .b_o     (b),
`ifdef MODHALFI_RANGE_CHK_EN
        .busy_o  (busy),
        .err_o   (err)
`else
        .busy_o  (busy)
`endif
    );

    // Advance past the next rising edge; outputs are stable when this returns.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [L*W-1:0] pack(input int l0, input int l1, input int l2, input int l3);
        logic [L*W-1:0] v;
        v = {W'(l3), W'(l2), W'(l1), W'(l0)};
        return v;
    endfunction

    function automatic int lane(input logic [L*W-1:0] v, input int i);
        return int'(v[i*W +: W]);
    endfunction

    // Present one transaction from IDLE and let the accept edge pass.
    task automatic send(input logic [L*W-1:0] vec, input int k);
        a     = vec;
        shamt = SW'(k);
        a_vld = 1'b1;
        step();
        a_vld = 1'b0;
    endtask

    // Count cycles from the accept edge until b_vld, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!b_vld && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a_vld = 1'b0; b_rdy = 1'b0; a = '0; shamt = '0;
        step();
        step();
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL reset_b_vld got=%0b want=0", b_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_a_rdy got=%0b want=1", a_rdy); end
        checks++; if (b !== '0) begin errors++; $display("FAIL reset_b got=%h want=0", b); end
`ifdef MODHALFI_RANGE_CHK_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_shift();
        int lat;
        int exp[4] = '{1665, 1, 0, 1664};
        b_rdy = 1'b1;
        a = pack(1, 2, 0, 3328); shamt = 3'd1; a_vld = 1'b1;
        #1;
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL single_a_rdy_idle got=%0b want=1", a_rdy); end
        step();
        a_vld = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_run got=%0b want=1", busy); end
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL single_b_vld_early got=%0b want=0", b_vld); end
        wait_done(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL single_latency got=%0d want=2", lat); end
        for (int i = 0; i < L; i++) begin
            checks++;
            if (lane(b, i) != exp[i]) begin
                errors++; $display("FAIL single_lane%0d got=%0d want=%0d", i, lane(b, i), exp[i]);
            end
        end
        step();
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL single_handoff_vld got=%0b want=0", b_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_handoff_busy got=%0b want=0", busy); end
    endtask

    task automatic test_max_shift();
        int lat;
        b_rdy = 1'b1;
        send(pack(1, 0, 0, 0), 7);
        lat = 1;
        while (!b_vld && lat < 20) begin
            checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL max_a_rdy_run got=%0b want=0", a_rdy); end
            step();
            lat++;
        end
        checks++; if (lat != 8) begin errors++; $display("FAIL max_latency got=%0d want=8", lat); end
        checks++; if (lane(b, 0) != 3303) begin errors++; $display("FAIL max_lane0 got=%0d want=3303", lane(b, 0)); end
        checks++; if (lane(b, 3) != 0) begin errors++; $display("FAIL max_lane3 got=%0d want=0", lane(b, 3)); end
        step();
    endtask

    task automatic test_hold();
        logic [L*W-1:0] exp;
        exp = pack(1234, 1234, 1234, 1234);
        b_rdy = 1'b0;
        send(exp, 0);
        checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL hold_b_vld got=%0b want=1", b_vld); end
        checks++; if (b !== exp) begin errors++; $display("FAIL hold_b got=%h want=%h", b, exp); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL hold_b_vld_c%0d got=%0b want=1", i, b_vld); end
            checks++; if (b !== exp) begin errors++; $display("FAIL hold_b_c%0d got=%h want=%h", i, b, exp); end
            checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL hold_a_rdy_c%0d got=%0b want=0", i, a_rdy); end
        end
        b_rdy = 1'b1;
        #1;
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL hold_a_rdy_release got=%0b want=1", a_rdy); end
        step();
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL hold_release_vld got=%0b want=0", b_vld); end
    endtask

    task automatic test_back_to_back();
        logic [L*W-1:0] exp1;
        logic [L*W-1:0] exp2;
        exp1 = pack(5, 1670, 6, 1671);
        exp2 = pack(50, 3328, 1668, 4);
        b_rdy = 1'b1;
        a = pack(10, 11, 12, 13); shamt = 3'd1; a_vld = 1'b1;
        step();
        a = pack(100, 3327, 7, 8);
        step();
        checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL b2b_first_vld got=%0b want=1", b_vld); end
        checks++; if (b !== exp1) begin errors++; $display("FAIL b2b_first_b got=%h want=%h", b, exp1); end
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL b2b_a_rdy_done got=%0b want=1", a_rdy); end
        step();
        a_vld = 1'b0;
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL b2b_reload_vld got=%0b want=0", b_vld); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reload_busy got=%0b want=1", busy); end
        step();
        checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL b2b_second_vld got=%0b want=1", b_vld); end
        checks++; if (b !== exp2) begin errors++; $display("FAIL b2b_second_b got=%h want=%h", b, exp2); end
        step();
    endtask

    task automatic test_abort();
        b_rdy = 1'b1;
        send(pack(5, 6, 7, 8), 7);
        step();
        step();
        rst = 1'b1;
        step();
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL abort_b_vld got=%0b want=0", b_vld); end
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL abort_a_rdy got=%0b want=1", a_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b want=0", busy); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL abort_no_result got=%0b want=0", b_vld); end
    endtask

    // Scale back by 2^7 mod Q and expect the original input.
    task automatic test_inverse_random();
        int lat;
        int av[4];
        b_rdy = 1'b1;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < L; i++) av[i] = int'($urandom_range(0, QM - 1));
            send(pack(av[0], av[1], av[2], av[3]), 7);
            wait_done(lat);
            checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL inv_t%0d_timeout got=%0b want=1", t, b_vld); end
            for (int i = 0; i < L; i++) begin
                checks++;
                if ((lane(b, i) * 128) % QM != av[i] || lane(b, i) >= QM) begin
                    errors++;
                    $display("FAIL inv_t%0d_lane%0d got=%0d want=b*128%%Q==%0d", t, i, lane(b, i), av[i]);
                end
            end
            step();
        end
    endtask

`ifdef MODHALFI_RANGE_CHK_EN
    task automatic test_range();
        int lat;
        b_rdy = 1'b1;
        send(pack(5, 6, 3329, 7), 1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_err_run got=%0b want=0", err); end
        wait_done(lat);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_err_set got=%0b want=1", err); end
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_err_handoff got=%0b want=0", err); end
        send(pack(5, 6, 3328, 7), 1);
        wait_done(lat);
        checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL range_ok_vld got=%0b want=1", b_vld); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_err_clear got=%0b want=0", err); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_shift();
        test_max_shift();
        test_hold();
        test_back_to_back();
        test_abort();
        test_inverse_random();
`ifdef MODHALFI_RANGE_CHK_EN
        test_range();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
